// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared types and helpers for the frame-buffer flush arbiter.
//   fb_state_t     : arbiter FSM states
//   SD_WORD_BYTES  : byte stride between consecutive SDRAM words
//   WORD_CNT_W     : width of the SD word counter
//   pack_sd_word() : widens a 24-bit RGB pixel to a 32-bit SDRAM word
// -----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FL_RD   = 3'd1,
        FL_WAIT = 3'd2,
        FL_WR   = 3'd3,
        FL_PAD  = 3'd4,
        DONE    = 3'd5
    } fb_state_t;

    localparam int SD_WORD_BYTES = 4;
    localparam int WORD_CNT_W    = 19;

    function automatic logic [31:0] pack_sd_word(input logic [23:0] rgb);
        return {8'h00, rgb};
    endfunction

endpackage

// File: rtl/fb_sd_writer.sv
// -----------------------------------------------------------------------------
// fb_sd_writer
// Avalon-MM write master stage. A load pulse captures address/data and raises
// sd_write; the outputs stay frozen while the slave asserts sd_waitrequest.
// accept marks the cycle the slave takes the word. A load in the same cycle as
// an accept chains the next word without a bubble.
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   load                capture load_address/load_data and raise sd_write
//   load_address[25:0]  byte address of the word to send
//   load_data[31:0]     word to send
//   sd_waitrequest      slave stall
//   sd_write            Avalon write strobe
//   sd_address[25:0]    Avalon byte address (SD_BASE after reset)
//   sd_writedata[31:0]  Avalon write data
//   accept              transfer completes this cycle
// -----------------------------------------------------------------------------
module fb_sd_writer #(
    parameter logic [25:0] SD_BASE = 26'h0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load,
    input  logic [25:0] load_address,
    input  logic [31:0] load_data,
    input  logic        sd_waitrequest,
    output logic        sd_write,
    output logic [25:0] sd_address,
    output logic [31:0] sd_writedata,
    output logic        accept
);

    assign accept = sd_write & ~sd_waitrequest;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sd_write     <= 1'b0;
            sd_address   <= SD_BASE;
            sd_writedata <= 32'h0;
        end else if (load) begin
            sd_write     <= 1'b1;
            sd_address   <= load_address;
            sd_writedata <= load_data;
        end else if (accept) begin
            sd_write     <= 1'b0;
        end
    end

endmodule

// File: rtl/fb_flush_arbiter.sv
// -----------------------------------------------------------------------------
// fb_flush_arbiter
// Owns the single M9 frame-buffer RAM port. In IDLE the alpha blender gets the
// port (write beats read). On frame_ready the RAM is handed to the flush
// engine, which streams NUM_PIXELS pixels to SDRAM as {8'h00, rgb}, pads with
// black words up to FRAME_WORDS, pulses flush_done and returns to IDLE.
// Optional feature: define FB_STALL_CNT_EN to add stall_cnt[31:0], a saturating
// count of SDRAM stall cycles plus blender requests refused during a flush.
// Ports:
//   clk, n_rst                     clock, asynchronous active-low reset
//   bl_wr_req/bl_rd_req            blender requests
//   bl_addr, bl_wdata              blender address / write pixel
//   bl_gnt                         request accepted this cycle (combinational)
//   bl_rdata, bl_rvalid            read pixel, one cycle after read grant
//   frame_ready                    start a flush (sampled in IDLE)
//   m9_we, m9_waddr, m9_wdata      M9 write port
//   m9_raddr, m9_rdata             M9 read port, 1-cycle registered latency
//   sd_write, sd_address,
//   sd_writedata, sd_waitrequest   Avalon-MM write master
//   flush_busy                     flush in progress (FL_RD .. DONE)
//   flush_done                     single-cycle pulse after the last word
//   stall_cnt                      only with FB_STALL_CNT_EN
// -----------------------------------------------------------------------------
module fb_flush_arbiter
    import fb_pkg::*;
#(
    parameter int          ADDR_W      = 17,
    parameter int          NUM_PIXELS  = 76800,
    parameter int          FRAME_WORDS = 307200,
    parameter logic [25:0] SD_BASE     = 26'h0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              bl_wr_req,
    input  logic              bl_rd_req,
    input  logic [ADDR_W-1:0] bl_addr,
    input  logic [23:0]       bl_wdata,
    output logic              bl_gnt,
    output logic [23:0]       bl_rdata,
    output logic              bl_rvalid,
    input  logic              frame_ready,
    output logic              m9_we,
    output logic [ADDR_W-1:0] m9_waddr,
    output logic [ADDR_W-1:0] m9_raddr,
    output logic [23:0]       m9_wdata,
    input  logic [23:0]       m9_rdata,
    output logic              sd_write,
    output logic [25:0]       sd_address,
    output logic [31:0]       sd_writedata,
    input  logic              sd_waitrequest,
    output logic              flush_busy,
    output logic              flush_done
`ifdef FB_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // Padding phase exists only when the frame is larger than the pixel store.
    localparam bit PAD_EN = (FRAME_WORDS > NUM_PIXELS);

    fb_state_t             state_reg;
    logic [ADDR_W-1:0]     pix_cnt_reg;
    logic [WORD_CNT_W-1:0] word_cnt_reg;
    logic                  flush_busy_reg;
    logic                  flush_done_reg;
    logic                  rvalid_reg;

    logic                  idle;
    logic                  bl_req;
    logic                  rd_gnt;
    logic                  last_pix;
    logic                  last_word;
    logic                  accept;
    logic                  load;
    logic [WORD_CNT_W-1:0] load_word;
    logic [25:0]           load_address;
    logic [31:0]           load_data;

    // ---------------------------------------------------------------- blender
    assign idle   = (state_reg == IDLE);
    assign bl_req = bl_wr_req | bl_rd_req;
    assign bl_gnt = bl_req & idle;
    // A simultaneous read loses to the write and simply stays requested.
    assign rd_gnt = bl_rd_req & ~bl_wr_req & idle;

    assign m9_we    = bl_wr_req & idle;
    assign m9_waddr = m9_we ? bl_addr : '0;
    assign m9_wdata = m9_we ? bl_wdata : 24'h0;
    // Outside IDLE the read port belongs to the flush engine.
    assign m9_raddr = idle ? (rd_gnt ? bl_addr : '0) : pix_cnt_reg;

    assign bl_rvalid  = rvalid_reg;
    assign bl_rdata   = rvalid_reg ? m9_rdata : 24'h0;
    assign flush_busy = flush_busy_reg;
    assign flush_done = flush_done_reg;

    // ------------------------------------------------------------ flush path
    assign last_pix  = (pix_cnt_reg  == ADDR_W'(NUM_PIXELS - 1));
    assign last_word = (word_cnt_reg == WORD_CNT_W'(FRAME_WORDS - 1));

    // New SD words are loaded when the pixel has arrived from M9 (end of
    // FL_WAIT), and back-to-back on every accept that is followed by a pad
    // word, so sd_write never drops inside the padding run.
    always_comb begin
        load = 1'b0;
        case (state_reg)
            FL_WAIT: load = 1'b1;
            FL_WR:   load = accept & last_pix & PAD_EN;
            FL_PAD:  load = accept & ~last_word;
            default: load = 1'b0;
        endcase
    end

    // In FL_WAIT the word counter already indexes the word being loaded; on a
    // chained load it has not yet been bumped for the word just accepted.
    assign load_word    = (state_reg == FL_WAIT) ? word_cnt_reg : word_cnt_reg + 1'b1;
    assign load_address = SD_BASE + 26'(load_word) * 26'(SD_WORD_BYTES);
    assign load_data    = (state_reg == FL_WAIT) ? pack_sd_word(m9_rdata) : 32'h0;

    fb_sd_writer #(
        .SD_BASE (SD_BASE)
    ) u_sd_writer (
        .clk            (clk),
        .n_rst          (n_rst),
        .load           (load),
        .load_address   (load_address),
        .load_data      (load_data),
        .sd_waitrequest (sd_waitrequest),
        .sd_write       (sd_write),
        .sd_address     (sd_address),
        .sd_writedata   (sd_writedata),
        .accept         (accept)
    );

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            pix_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            flush_busy_reg <= 1'b0;
            flush_done_reg <= 1'b0;
            rvalid_reg     <= 1'b0;
        end else begin
            flush_done_reg <= 1'b0;
            rvalid_reg     <= rd_gnt;
            case (state_reg)
                IDLE: begin
                    if (frame_ready) begin
                        state_reg      <= FL_RD;
                        flush_busy_reg <= 1'b1;
                    end
                end
                FL_RD:   state_reg <= FL_WAIT;
                FL_WAIT: state_reg <= FL_WR;
                FL_WR: begin
                    if (accept) begin
                        pix_cnt_reg  <= pix_cnt_reg + 1'b1;
                        word_cnt_reg <= word_cnt_reg + 1'b1;
                        if (!last_pix) begin
                            state_reg <= FL_RD;
                        end else if (PAD_EN) begin
                            state_reg <= FL_PAD;
                        end else begin
                            state_reg      <= DONE;
                            flush_done_reg <= 1'b1;
                        end
                    end
                end
                FL_PAD: begin
                    if (accept) begin
                        word_cnt_reg <= word_cnt_reg + 1'b1;
                        if (last_word) begin
                            state_reg      <= DONE;
                            flush_done_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg      <= IDLE;
                    flush_busy_reg <= 1'b0;
                    pix_cnt_reg    <= '0;
                    word_cnt_reg   <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FB_STALL_CNT_EN
    // Both stall sources can hit in one cycle, so the increment is 0..2.
    logic [1:0]  stall_inc;
    logic [32:0] stall_sum;

    assign stall_inc = {1'b0, sd_write & sd_waitrequest} + {1'b0, bl_req & ~idle};
    assign stall_sum = {1'b0, stall_cnt} + 33'(stall_inc);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt <= 32'h0;
        end else begin
            stall_cnt <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
        end
    end
`endif

endmodule
